lsu_memoria: RTL and testbench

- Load/store unit downstream of the ALU. It takes the ALU result (effective address for LW/SW and the byte/half variants) plus rs2 store data.
- Runs one request/acknowledge transaction on the data-memory port.
- Returns aligned, sign/zero-extended load data for register write-back, or flags a misaligned/illegal access.
- Multi-cycle: the core stalls on BUSY.

---
 rtl/lsu_memoria_if.sv | 23 ++
 rtl/lsu_memoria.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_memoria.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_memoria_if.sv
// Data-memory port of the load/store unit: level-held request, single-cycle acknowledge.
// The LSU drives it through the master modport; the memory model uses the slave modport.
interface lsu_memoria_if #(
    parameter int unsigned ANCHO_DATOS = 32
);
    logic                       mem_req;
    logic                       mem_we;
    logic [ANCHO_DATOS-1:0]     mem_addr;
    logic [ANCHO_DATOS/8-1:0]   mem_be;
    logic [ANCHO_DATOS-1:0]     mem_wdata;
    logic                       mem_ack;
    logic [ANCHO_DATOS-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_memoria.sv
// Load/store unit: one request/ack memory transaction per accepted START, with byte-lane
// steering, load extension and misalignment detection. Optional ACK timeout via LSU_TIMEOUT_EN.
module lsu_memoria #(
    parameter int unsigned ANCHO_DATOS    = 32,
    parameter int unsigned TIMEOUT_CICLOS = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   es_store_i,
    input  logic [2:0]             funct3_i,
    input  logic [ANCHO_DATOS-1:0] dir_i,
    input  logic [ANCHO_DATOS-1:0] dato_w_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ANCHO_DATOS-1:0] dato_r_o,
    output logic                   err_alin_o,
    output logic                   err_timeout_o,
    lsu_memoria_if.master          mem
);

    if (ANCHO_DATOS != 32 || TIMEOUT_CICLOS == 0) begin : g_param_chk
        $error("lsu_memoria: only ANCHO_DATOS=32 and TIMEOUT_CICLOS>0 are supported");
    end

    typedef enum logic [1:0] {
        REPOSO,
        ACCESO,
        FIN
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [31:0] dir_q, dir_d;
    logic [31:0] dato_w_q, dato_w_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [31:0] dato_r_q, dato_r_d;
    logic        err_alin_q, err_alin_d;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CICLOS + 1) > 8) ?
                                    $clog2(TIMEOUT_CICLOS + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_to_q, err_to_d;
`endif

    logic        acceso_ok;
    logic [31:0] dato_carga;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Legality and alignment are judged on the raw inputs so the error path needs no extra cycle.
    always_comb begin
        acceso_ok = 1'b0;
        unique case (funct3_i)
            3'b000:  acceso_ok = 1'b1;
            3'b001:  acceso_ok = ~dir_i[0];
            3'b010:  acceso_ok = (dir_i[1:0] == 2'b00);
            3'b100:  acceso_ok = ~es_store_i;
            3'b101:  acceso_ok = ~es_store_i & ~dir_i[0];
            default: acceso_ok = 1'b0;
        endcase
    end

    always_comb begin
        byte_sel = 8'h00;
        unique case (dir_q[1:0])
            2'b00: byte_sel = mem.mem_rdata[7:0];
            2'b01: byte_sel = mem.mem_rdata[15:8];
            2'b10: byte_sel = mem.mem_rdata[23:16];
            2'b11: byte_sel = mem.mem_rdata[31:24];
        endcase
        half_sel = dir_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

        dato_carga = mem.mem_rdata;
        unique case (funct3_q)
            3'b000:  dato_carga = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  dato_carga = {{16{half_sel[15]}}, half_sel};
            3'b100:  dato_carga = {24'h000000, byte_sel};
            3'b101:  dato_carga = {16'h0000, half_sel};
            default: dato_carga = mem.mem_rdata;
        endcase
    end

    always_comb begin
        estado_d   = estado_q;
        dir_d      = dir_q;
        dato_w_d   = dato_w_q;
        funct3_d   = funct3_q;
        store_d    = store_q;
        dato_r_d   = dato_r_q;
        err_alin_d = err_alin_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = '0;
        err_to_d   = err_to_q;
`endif

        unique case (estado_q)
            REPOSO: begin
                if (start_i) begin
                    dir_d      = dir_i;
                    dato_w_d   = dato_w_i;
                    funct3_d   = funct3_i;
                    store_d    = es_store_i;
                    err_alin_d = ~acceso_ok;
`ifdef LSU_TIMEOUT_EN
                    err_to_d   = 1'b0;
`endif
                    estado_d   = acceso_ok ? ACCESO : FIN;
                end
            end
            ACCESO: begin
                if (mem.mem_ack) begin
                    estado_d = FIN;
                    if (!store_q) begin
                        dato_r_d = dato_carga;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1)) begin
                    // The TIMEOUT_CICLOS-th cycle without ACK ends the access; ACK still wins above.
                    estado_d = FIN;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            FIN: begin
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            estado_q   <= REPOSO;
            dir_q      <= '0;
            dato_w_q   <= '0;
            funct3_q   <= '0;
            store_q    <= 1'b0;
            dato_r_q   <= '0;
            err_alin_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
            err_to_q   <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            dir_q      <= dir_d;
            dato_w_q   <= dato_w_d;
            funct3_q   <= funct3_d;
            store_q    <= store_d;
            dato_r_q   <= dato_r_d;
            err_alin_q <= err_alin_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_to_q   <= err_to_d;
`endif
        end
    end

    logic en_acceso;
    assign en_acceso = (estado_q == ACCESO);

    // Bus fields are forced to zero outside ACCESO so nothing leaks onto the port while idle.
    always_comb begin
        mem.mem_req   = en_acceso;
        mem.mem_we    = en_acceso & store_q;
        mem.mem_addr  = '0;
        mem.mem_be    = '0;
        mem.mem_wdata = '0;
        if (en_acceso) begin
            mem.mem_addr = {dir_q[31:2], 2'b00};
            unique case (funct3_q[1:0])
                2'b00: begin
                    mem.mem_be    = 4'b0001 << dir_q[1:0];
                    mem.mem_wdata = {4{dato_w_q[7:0]}};
                end
                2'b01: begin
                    mem.mem_be    = dir_q[1] ? 4'b1100 : 4'b0011;
                    mem.mem_wdata = {2{dato_w_q[15:0]}};
                end
                default: begin
                    mem.mem_be    = 4'b1111;
                    mem.mem_wdata = dato_w_q;
                end
            endcase
        end
    end

    assign busy_o     = (estado_q != REPOSO);
    assign done_o     = (estado_q == FIN);
    assign dato_r_o   = dato_r_q;
    assign err_alin_o = err_alin_q;
`ifdef LSU_TIMEOUT_EN
    assign err_timeout_o = err_to_q;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_memoria.sv
// Directed bench for lsu_memoria: hand-computed vectors for loads, stores, errors,
// busy/back-to-back behaviour, reset abort and (with LSU_TIMEOUT_EN) the ACK timeout.
module tb_lsu_memoria;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        es_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] dir_i;
    logic [31:0] dato_w_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] dato_r_o;
    logic        err_alin_o;
    logic        err_timeout_o;

    int checks = 0;
    int errors = 0;

    lsu_memoria_if #(.ANCHO_DATOS(32)) bus ();

    lsu_memoria #(
        .ANCHO_DATOS    (32),
        .TIMEOUT_CICLOS (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .es_store_i    (es_store_i),
        .funct3_i      (funct3_i),
        .dir_i         (dir_i),
        .dato_w_i      (dato_w_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .dato_r_o      (dato_r_o),
        .err_alin_o    (err_alin_o),
        .err_timeout_o (err_timeout_o),
        .mem           (bus.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] d, input logic [31:0] w);
        start_i    = 1'b1;
        es_store_i = st;
        funct3_i   = f3;
        dir_i      = d;
        dato_w_i   = w;
        tick();
        start_i    = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; es_store_i = 1'b0; funct3_i = '0;
        dir_i = '0; dato_w_i = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tick(); tick();
        rst_i = 1'b0;

        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("rst_done",  {31'd0, done_o}, 32'd0);
        chk("rst_dator", dato_r_o, 32'h0);
        chk("rst_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("rst_err",   {30'd0, err_alin_o, err_timeout_o}, 32'd0);

        // LW aligned, ACK in cycle 2, DONE in cycle 3
        req(1'b0, 3'b010, 32'h0000_0104, 32'h0);
        chk("lw_req",  {31'd0, bus.mem_req}, 32'd1);
        chk("lw_addr", bus.mem_addr, 32'h0000_0104);
        chk("lw_be",   {28'd0, bus.mem_be}, 32'hF);
        chk("lw_we",   {31'd0, bus.mem_we}, 32'd0);
        chk("lw_busy", {31'd0, busy_o}, 32'd1);
        tick();
        chk("lw_c2_done", {31'd0, done_o}, 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_ack = 1'b0;
        chk("lw_done",  {31'd0, done_o}, 32'd1);
        chk("lw_dator", dato_r_o, 32'hDEAD_BEEF);
        chk("lw_err",   {31'd0, err_alin_o}, 32'd0);
        chk("lw_reqlo", {31'd0, bus.mem_req}, 32'd0);
        tick();
        chk("lw_idle",  {30'd0, busy_o, done_o}, 32'd0);

        // LB then LBU at 0x203; LBU starts the cycle right after DONE
        req(1'b0, 3'b000, 32'h0000_0203, 32'h0);
        chk("lb_be",   {28'd0, bus.mem_be}, 32'h8);
        chk("lb_addr", bus.mem_addr, 32'h0000_0200);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8011_2233;
        tick();
        bus.mem_ack = 1'b0;
        chk("lb_done",  {31'd0, done_o}, 32'd1);
        chk("lb_dator", dato_r_o, 32'hFFFF_FF80);
        tick();
        req(1'b0, 3'b100, 32'h0000_0203, 32'h0);
        chk("lbu_accepted", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8011_2233;
        tick();
        bus.mem_ack = 1'b0;
        chk("lbu_dator", dato_r_o, 32'h0000_0080);
        tick();

        // SH upper half: store leaves DATO_R alone
        req(1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD);
        chk("sh_addr",  bus.mem_addr, 32'h0000_0010);
        chk("sh_be",    {28'd0, bus.mem_be}, 32'hC);
        chk("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
        chk("sh_we",    {31'd0, bus.mem_we}, 32'd1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_ack = 1'b0;
        chk("sh_done",  {31'd0, done_o}, 32'd1);
        chk("sh_dator", dato_r_o, 32'h0000_0080);
        tick();

        // SB lane 1 and LH/LHU extension
        req(1'b1, 3'b000, 32'h0000_0001, 32'h1234_565A);
        chk("sb_be",    {28'd0, bus.mem_be}, 32'h2);
        chk("sb_wdata", bus.mem_wdata, 32'h5A5A_5A5A);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        req(1'b0, 3'b001, 32'h0000_0022, 32'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8001_7FFF;
        tick();
        bus.mem_ack = 1'b0;
        chk("lh_dator", dato_r_o, 32'hFFFF_8001);
        tick();
        req(1'b0, 3'b101, 32'h0000_0020, 32'h0);
        chk("lhu_be", {28'd0, bus.mem_be}, 32'h3);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8001_F00F;
        tick();
        bus.mem_ack = 1'b0;
        chk("lhu_dator", dato_r_o, 32'h0000_F00F);
        tick();

        // Misaligned LW, illegal load funct3, illegal store funct3
        req(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        chk("mis_done", {31'd0, done_o}, 32'd1);
        chk("mis_err",  {31'd0, err_alin_o}, 32'd1);
        chk("mis_req",  {31'd0, bus.mem_req}, 32'd0);
        tick();
        chk("mis_idle", {30'd0, busy_o, done_o}, 32'd0);
        req(1'b0, 3'b011, 32'h0000_0000, 32'h0);
        chk("f3_011", {30'd0, done_o, err_alin_o}, 32'd3);
        chk("f3_req", {31'd0, bus.mem_req}, 32'd0);
        tick();
        req(1'b1, 3'b100, 32'h0000_0000, 32'h0);
        chk("sbu_illegal", {30'd0, done_o, err_alin_o}, 32'd3);
        tick();

        // START during ACCESO and FIN ignored; error flag cleared by new START
        req(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        chk("bsy_errclr", {31'd0, err_alin_o}, 32'd0);
        start_i = 1'b1; es_store_i = 1'b1; funct3_i = 3'b000;
        dir_i = 32'h0000_0081; dato_w_i = 32'hFFFF_FFFF;
        tick();
        start_i = 1'b0;
        chk("bsy_addr", bus.mem_addr, 32'h0000_0040);
        chk("bsy_be",   {28'd0, bus.mem_be}, 32'hF);
        chk("bsy_we",   {31'd0, bus.mem_we}, 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        bus.mem_ack = 1'b0;
        chk("bsy_dator", dato_r_o, 32'h0BAD_F00D);
        req(1'b0, 3'b010, 32'h0000_0001, 32'h0);
        chk("fin_start_ign", {29'd0, busy_o, done_o, bus.mem_req}, 32'd0);

        // ACK together with the first REQ: DONE two cycles after START
        req(1'b0, 3'b010, 32'h0000_0008, 32'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1122_3344;
        tick();
        bus.mem_ack = 1'b0;
        chk("fast_done",  {31'd0, done_o}, 32'd1);
        chk("fast_dator", dato_r_o, 32'h1122_3344);
        tick();

        // ACK with no request outstanding is ignored
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_CAFE;
        tick(); tick();
        bus.mem_ack = 1'b0;
        chk("ack_idle",       {30'd0, busy_o, done_o}, 32'd0);
        chk("ack_idle_dator", dato_r_o, 32'h1122_3344);

        // Reset while MEM_REQ is high
        req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        chk("rstm_req", {31'd0, bus.mem_req}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstm_drop",  {29'd0, bus.mem_req, busy_o, done_o}, 32'd0);
        chk("rstm_dator", dato_r_o, 32'h0);
        tick();
        chk("rstm_nodone", {31'd0, done_o}, 32'd0);

`ifdef LSU_TIMEOUT_EN
        // No ACK: four cycles in ACCESO, DONE with ERR_TIMEOUT on the fifth
        req(1'b0, 3'b010, 32'h0000_0030, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("to_waiting", {30'd0, bus.mem_req, done_o}, 32'd2);
            tick();
        end
        chk("to_last_req", {31'd0, bus.mem_req}, 32'd1);
        tick();
        chk("to_done", {29'd0, done_o, err_timeout_o, bus.mem_req}, 32'd6);
        chk("to_dator", dato_r_o, 32'h0);
        tick();
        // ACK on the limit cycle wins
        req(1'b0, 3'b010, 32'h0000_0030, 32'h0);
        chk("to2_errclr", {31'd0, err_timeout_o}, 32'd0);
        tick(); tick(); tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        tick();
        bus.mem_ack = 1'b0;
        chk("to2_done",  {30'd0, done_o, err_timeout_o}, 32'd2);
        chk("to2_dator", dato_r_o, 32'h5555_AAAA);
        tick();
`else
        chk("to_tied", {31'd0, err_timeout_o}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
